// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants for the write-back stage
package mips_pkg;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [PKG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - big-endian sub-word select, extension and alignment check
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data,
  output logic        o_misaligned
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[31:24];
    case (i_offset)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
  end

  // Size 2'b11 falls into the word branch on purpose.
  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
    o_misaligned = ((i_size == SZ_HALF) & i_offset[0]) | (i_size[1] & (i_offset != 2'b00));
  end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, write-data select and ID read bypass
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] id_read_reg1,
  input  logic [ADDR_W-1:0] id_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [DATA_W-1:0] id_read_data1,
  output logic [DATA_W-1:0] id_read_data2,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  instret
);
  logic              r_valid, r_fresh;
  logic              r_reg_write, r_mem_to_reg, r_link, r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_alu_result, r_read_data, r_pc_plus4;
  logic              r_misalign_err;
  logic [CNT_W-1:0]  r_instret;

  logic [DATA_W-1:0] w_load_data;
  logic              w_ext_misaligned;
  logic              w_misaligned;

  load_extract u_load_extract (
    .i_word      (r_read_data),
    .i_offset    (r_alu_result[1:0]),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .o_data      (w_load_data),
    .o_misaligned(w_ext_misaligned)
  );

  assign w_misaligned = r_mem_to_reg & w_ext_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_fresh        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_link         <= 1'b0;
      r_signed       <= 1'b0;
      r_size         <= '0;
      r_write_reg    <= '0;
      r_alu_result   <= '0;
      r_read_data    <= '0;
      r_pc_plus4     <= '0;
      r_misalign_err <= 1'b0;
      r_instret      <= '0;
    end else begin
      // The entry currently in WB retires regardless of what MEM does this cycle.
      if (r_fresh & r_valid) begin
        r_instret <= r_instret + CNT_W'(1);
        if (w_misaligned) r_misalign_err <= 1'b1;
      end
      if (flush) begin
        r_valid <= 1'b0;
        r_fresh <= 1'b0;
      end else if (stall) begin
        r_fresh <= 1'b0;
      end else begin
        r_valid      <= mem_valid;
        r_fresh      <= mem_valid;
        r_reg_write  <= mem_reg_write;
        r_mem_to_reg <= mem_mem_to_reg;
        r_link       <= mem_link;
        r_signed     <= mem_signed;
        r_size       <= mem_size;
        r_write_reg  <= mem_write_reg;
        r_alu_result <= mem_alu_result;
        r_read_data  <= mem_read_data;
        r_pc_plus4   <= mem_pc_plus4;
      end
    end
  end

  always_comb begin
    RegWrite   = r_fresh & r_reg_write & (r_write_reg != ADDR_W'(REG_ZERO)) & ~w_misaligned;
    write_reg  = r_write_reg;
    write_data = r_link ? r_pc_plus4 : (r_mem_to_reg ? w_load_data : r_alu_result);
  end

  // The register file reads before it writes, so a same-edge write is forwarded here.
  always_comb begin
    id_read_data1 = (RegWrite && (write_reg == id_read_reg1)) ? write_data : rf_read_data1;
    id_read_data2 = (RegWrite && (write_reg == id_read_reg2)) ? write_data : rf_read_data2;
  end

  assign misalign_err = r_misalign_err;
  assign instret      = r_instret;
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MIPS write-back stage; the initiator side of the register-file write port.
- Holds the MEM/WB pipeline register and selects write data (ALU result, sign/zero-extended load data, or link address).
- Drives write_reg / write_data / RegWrite into the register file exactly once per retiring instruction.
- Supplies the ID-stage read bypass. The register file samples read data before writing on the same edge, so a same-cycle write would otherwise be missed.

Parameters:
- DATA_W, 32, datapath width (only 32 supported).
- ADDR_W, 5, register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes a register.
- mem_mem_to_reg  in  1  write data comes from load data.
- mem_link  in  1  write data is PC+4 (jal/jalr).
- mem_size  in  2  load size: 00 byte, 01 half, 10 word.
- mem_signed  in  1  sign-extend sub-word load.
- mem_write_reg  in  ADDR_W  destination register.
- mem_alu_result  in  DATA_W  ALU result / load address.
- mem_read_data  in  DATA_W  aligned data-memory word.
- mem_pc_plus4  in  DATA_W  link value.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  invalidate the incoming instruction.
- write_reg  out  ADDR_W  to register file.
- write_data  out  DATA_W  to register file.
- RegWrite  out  1  to register file.
- id_read_reg1, id_read_reg2  in  ADDR_W  ID-stage read indices.
- rf_read_data1, rf_read_data2  in  DATA_W  raw register-file outputs.
- id_read_data1, id_read_data2  out  DATA_W  bypassed read data.
- misalign_err  out  1  sticky misaligned-load flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- All state updates on posedge clk. Reset has priority over flush; flush has priority over stall.
- rst=1:
  - wb_valid=0, wb_fresh=0, misalign_err=0, instret=0, all held fields 0.
  - Resulting outputs: RegWrite=0, write_reg=0, write_data=0.
- flush=1 (rst=0): wb_valid<=0, wb_fresh<=0; other fields don't-care.
- stall=1: all held fields unchanged; wb_fresh<=0.
- Otherwise (normal load): capture all mem_* fields; wb_valid<=mem_valid, wb_fresh<=mem_valid.
- Latency: one cycle from MEM inputs to the register-file write port.
- RegWrite = wb_fresh & wb_reg_write & (wb_write_reg != 0) & ~misaligned.
  - Register 0 is never written.
  - A stalled entry writes only in its first WB cycle.
- write_reg = wb_write_reg. It is driven even when RegWrite=0.
- write_data priority: wb_link → wb_pc_plus4; else wb_mem_to_reg → load_data; else wb_alu_result.
- load_data is big-endian, with address offset a = wb_alu_result[1:0]:
  - Byte: byte k = word[31-8a -: 8].
  - Half: a[1]=0 → word[31:16]; a[1]=1 → word[15:0].
  - Word: the whole word.
  - Sub-word results are sign- or zero-extended per wb_signed.
- Misaligned: wb_mem_to_reg & ((half & a[0]) | (word & a!=0)).
  - The write is suppressed.
  - misalign_err<=1 if the entry is fresh. It stays set until rst.
- mem_size=11 is treated as word.
- instret increments by 1 on each cycle with wb_fresh & wb_valid, including misaligned and non-writing instructions. It wraps at 2^CNT_W.
- Bypass (combinational): id_read_dataN = (RegWrite & write_reg==id_read_regN) ? write_data : rf_read_dataN.
  - Index 0 is never bypassed, because RegWrite is 0 for index 0.

Decomposition:
- Shared package mips_pkg:
  - load size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - register index constant REG_ZERO;
  - DATA_W/ADDR_W defaults.
- One sub-module: load_extract.
  - Combinational.
  - Inputs: word, offset, size, signed.
  - Outputs: data, misaligned.
  - Instantiated once in wb_stage.

Test Plan:
- rst for 2 cycles, then idle:
  - RegWrite=0, instret=0, misalign_err=0.
  - id_read_data1 equals rf_read_data1=0xDEADBEEF.
- ALU write (mem_valid=1, reg_write=1, write_reg=8, alu=0x00000005):
  - next cycle RegWrite=1, write_reg=8, write_data=5;
  - instret=1 one cycle later;
  - with id_read_reg1=8 and rf_read_data1=0, id_read_data1=5.
- Load byte, mem_read_data=0x11228344, alu=0x1002:
  - signed → write_data=0xFFFFFF83;
  - unsigned → 0x00000083;
  - half, alu=0x1002, signed → 0xFFFF8344.
- Misaligned half (alu=0x1001, mem_to_reg=1):
  - RegWrite=0, misalign_err=1 and stays set after further valid instructions;
  - instret still increments.
- Stall for 3 cycles on a write to reg 9:
  - RegWrite=1 only in the first cycle;
  - instret +1 total.
- flush in the same cycle as a valid write to reg 10:
  - no RegWrite, instret unchanged.
- Write to reg 0 with link=1:
  - RegWrite=0, and bypass for id_read_reg1=0 returns the rf value.
